// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO: operation encodings and count-width helper.
package stack_pkg;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_REPL = 2'd3;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH, one synchronous write port and one asynchronous read port.
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO with replace-top, overflow/underflow pulses and synchronous flush.
// Optional peak-occupancy tracking is enabled by defining STACK_HIGH_WATER_EN.
module param_stack
    import stack_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int CW    = calc_cw(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             stack_empty,
    output logic             stack_full,
`ifdef STACK_HIGH_WATER_EN
    output logic [CW-1:0]    high_water,
`endif
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    count_r, count_nxt_s, count_m1_s;
    logic [WIDTH-1:0] data_out_r, data_out_nxt_s, rd_data_s;
    logic             pop_valid_r, pop_valid_nxt_s;
    logic             overflow_r, overflow_nxt_s;
    logic             underflow_r, underflow_nxt_s;
    logic             we_s, ram_we_s;
    logic [AW-1:0]    waddr_s, raddr_s;
    logic [1:0]       op_s;
    logic             empty_s, full_s;

    assign op_s       = {pop, push};
    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == CW'(DEPTH));
    assign count_m1_s = count_r - CW'(1);
    assign raddr_s    = count_m1_s[AW-1:0];

    // Next-state decode: flush first, then the requested operation.
    always_comb begin
        count_nxt_s     = count_r;
        data_out_nxt_s  = data_out_r;
        pop_valid_nxt_s = 1'b0;
        overflow_nxt_s  = 1'b0;
        underflow_nxt_s = 1'b0;
        we_s            = 1'b0;
        waddr_s         = count_r[AW-1:0];
        if (flush) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            case (op_s)
                OP_PUSH: begin
                    if (full_s) begin
                        overflow_nxt_s = 1'b1;
                    end else begin
                        we_s        = 1'b1;
                        count_nxt_s = count_r + CW'(1);
                    end
                end
                OP_POP: begin
                    if (empty_s) begin
                        underflow_nxt_s = 1'b1;
                    end else begin
                        data_out_nxt_s  = rd_data_s;
                        pop_valid_nxt_s = 1'b1;
                        count_nxt_s     = count_m1_s;
                    end
                end
                OP_REPL: begin
                    // Replace-top keeps occupancy, so it is legal even when full.
                    if (empty_s) begin
                        we_s        = 1'b1;
                        count_nxt_s = CW'(1);
                    end else begin
                        data_out_nxt_s  = rd_data_s;
                        pop_valid_nxt_s = 1'b1;
                        we_s            = 1'b1;
                        waddr_s         = raddr_s;
                    end
                end
                OP_IDLE: begin
                    count_nxt_s = count_r;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Occupancy and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r     <= {CW{1'b0}};
            data_out_r  <= {WIDTH{1'b0}};
            pop_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            data_out_r  <= data_out_nxt_s;
            pop_valid_r <= pop_valid_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

`ifdef STACK_HIGH_WATER_EN
    logic [CW-1:0] high_water_r;

    // Peak occupancy, cleared along with the stack on flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            high_water_r <= {CW{1'b0}};
        end else if (flush) begin
            high_water_r <= {CW{1'b0}};
        end else if (count_nxt_s > high_water_r) begin
            high_water_r <= count_nxt_s;
        end
    end

    assign high_water = high_water_r;
`endif

    // A write coinciding with reset assertion is dropped.
    assign ram_we_s = we_s & reset;

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .waddr (waddr_s),
        .wdata (data_in),
        .raddr (raddr_s),
        .rdata (rd_data_s)
    );

    assign top         = empty_s ? {WIDTH{1'b0}} : rd_data_s;
    assign data_out    = data_out_r;
    assign pop_valid   = pop_valid_r;
    assign count       = count_r;
    assign stack_empty = empty_s;
    assign stack_full  = full_s;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed scenarios plus randomized traffic against a queue model.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             push  = 1'b0;
    logic             pop   = 1'b0;
    logic [WIDTH-1:0] data_in = 8'h00;
    logic [WIDTH-1:0] data_out, top;
    logic             pop_valid, stack_empty, stack_full, overflow, underflow;
    logic [CW-1:0]    count;
`ifdef STACK_HIGH_WATER_EN
    logic [CW-1:0]    high_water;
`endif

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .push        (push),
        .pop         (pop),
        .data_in     (data_in),
        .data_out    (data_out),
        .pop_valid   (pop_valid),
        .top         (top),
        .count       (count),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
`ifdef STACK_HIGH_WATER_EN
        .high_water  (high_water),
`endif
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] stk[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_pv, m_ov, m_uf;
    int               m_hw;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        stk.delete();
        m_dout = '0;
        m_pv   = 1'b0;
        m_ov   = 1'b0;
        m_uf   = 1'b0;
        m_hw   = 0;
    endtask

    task automatic model_step(input logic f, input logic pu, input logic po, input logic [WIDTH-1:0] din);
        m_pv = 1'b0;
        m_ov = 1'b0;
        m_uf = 1'b0;
        if (f) begin
            stk.delete();
            m_hw = 0;
        end else begin
            if (pu && !po) begin
                if (stk.size() < DEPTH) stk.push_back(din);
                else m_ov = 1'b1;
            end else if (po && !pu) begin
                if (stk.size() > 0) begin
                    m_dout = stk.pop_back();
                    m_pv   = 1'b1;
                end else m_uf = 1'b1;
            end else if (po && pu) begin
                if (stk.size() > 0) begin
                    m_dout = stk[stk.size()-1];
                    stk[stk.size()-1] = din;
                    m_pv = 1'b1;
                end else stk.push_back(din);
            end
            if (stk.size() > m_hw) m_hw = stk.size();
        end
    endtask

    task automatic check_all();
        logic [WIDTH-1:0] exp_top;
        exp_top = (stk.size() == 0) ? '0 : stk[stk.size()-1];
        check_val("count", 32'(count), 32'(stk.size()));
        check_val("empty", 32'(stack_empty), 32'(stk.size() == 0));
        check_val("full", 32'(stack_full), 32'(stk.size() == DEPTH));
        check_val("top", 32'(top), 32'(exp_top));
        check_val("data_out", 32'(data_out), 32'(m_dout));
        check_val("pop_valid", 32'(pop_valid), 32'(m_pv));
        check_val("overflow", 32'(overflow), 32'(m_ov));
        check_val("underflow", 32'(underflow), 32'(m_uf));
`ifdef STACK_HIGH_WATER_EN
        check_val("high_water", 32'(high_water), 32'(m_hw));
`endif
    endtask

    task automatic cycle(input logic f, input logic pu, input logic po, input logic [WIDTH-1:0] din);
        @(negedge clock);
        flush   = f;
        push    = pu;
        pop     = po;
        data_in = din;
        @(posedge clock);
        model_step(f, pu, po, din);
        #1;
        check_all();
    endtask

    initial begin
        int r;
        logic pu, po, f;
        int push_bias;

        model_reset();
        #12;
        check_all();
        check_val("rst_empty", 32'(stack_empty), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
        check_val("fill_count", 32'(count), 32'd16);
        check_val("fill_full", 32'(stack_full), 32'd1);
        check_val("fill_top", 32'(top), 32'h10);
        check_val("fill_ovf", 32'(overflow), 32'd0);

        cycle(1'b0, 1'b1, 1'b0, 8'hEE);
        check_val("ovf_pulse", 32'(overflow), 32'd1);
        check_val("ovf_count", 32'(count), 32'd16);
        check_val("ovf_top", 32'(top), 32'h10);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check_val("ovf_clear", 32'(overflow), 32'd0);

        for (int i = 16; i >= 1; i--) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            check_val("pop_data", 32'(data_out), 32'(i));
            check_val("pop_valid_d", 32'(pop_valid), 32'd1);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check_val("udf_pulse", 32'(underflow), 32'd1);
        check_val("udf_data", 32'(data_out), 32'h01);
        check_val("udf_pv", 32'(pop_valid), 32'd0);

        cycle(1'b0, 1'b1, 1'b0, 8'h11);
        cycle(1'b0, 1'b1, 1'b0, 8'h22);
        cycle(1'b0, 1'b1, 1'b0, 8'h33);
        cycle(1'b0, 1'b1, 1'b1, 8'hAA);
        check_val("repl_data", 32'(data_out), 32'h33);
        check_val("repl_top", 32'(top), 32'hAA);
        check_val("repl_count", 32'(count), 32'd3);

        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h55);
        check_val("pp_empty_count", 32'(count), 32'd1);
        check_val("pp_empty_top", 32'(top), 32'h55);
        check_val("pp_empty_pv", 32'(pop_valid), 32'd0);
        check_val("pp_empty_udf", 32'(underflow), 32'd0);

        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
`ifdef STACK_HIGH_WATER_EN
        check_val("hw_peak", 32'(high_water), 32'd5);
`endif
        cycle(1'b1, 1'b1, 1'b1, 8'h77);
        check_val("flush_count", 32'(count), 32'd0);
`ifdef STACK_HIGH_WATER_EN
        check_val("hw_flush", 32'(high_water), 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            push_bias = ((n / 150) % 2 == 0) ? 70 : 30;
            r  = $urandom_range(0, 99);
            f  = (r < 2);
            pu = ($urandom_range(0, 99) < push_bias);
            po = ($urandom_range(0, 99) < (100 - push_bias));
            cycle(f, pu, po, 8'($urandom));
            if (n == 1500) begin
                @(negedge clock);
                reset = 1'b0;
                push  = 1'b1;
                data_in = 8'h99;
                #2;
                model_reset();
                check_all();
                @(posedge clock);
                #1;
                check_all();
                @(negedge clock);
                reset = 1'b1;
                push  = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
